jericalla_fetch: RTL and testbench

JERICALLA_FETCH -- requirements
Module: jericalla_fetch

---
 rtl/jericalla_fetch.sv | 99 +++++++++
 tb/tb_jericalla_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/jericalla_fetch.sv
// Instruction fetch stage: program-loadable instruction memory, PC and a
// registered instruction output with bubble, stall, jump and halt handling.
module jericalla_fetch #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [17:0] NOP_WORD  = 18'h00000,
    parameter logic [17:0] HALT_WORD = 18'h3FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [17:0]       prog_data,
    input  logic              run,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [17:0]       instruccion,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt, pc_out_nxt;
    logic [17:0]         instr_nxt;
    logic                valid_nxt;
    logic [17:0]         mem [2**ADDR_W];
    logic [17:0]         mem_word;

    assign mem_word = mem[pc];
    assign halted   = (state == HALT);

    // Memory is deliberately outside the reset domain so programs survive reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instruccion <= NOP_WORD;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruccion <= instr_nxt;
            instr_valid <= valid_nxt;
            pc_out      <= pc_out_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instruccion;
        valid_nxt  = instr_valid;
        pc_out_nxt = pc_out;
        case (state)
            IDLE: begin
                instr_nxt = NOP_WORD;
                valid_nxt = 1'b0;
                if (run) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                end
            end
            FETCH: begin
                // Jump outranks stall and halt detection.
                if (jump) begin
                    pc_nxt    = jump_target;
                    instr_nxt = NOP_WORD;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    pc_nxt = pc;
                end else if (mem_word == HALT_WORD) begin
                    instr_nxt = NOP_WORD;
                    valid_nxt = 1'b0;
                    state_nxt = HALT;
                end else begin
                    instr_nxt  = mem_word;
                    valid_nxt  = 1'b1;
                    pc_out_nxt = pc;
                    pc_nxt     = pc + 1'b1;
                end
            end
            HALT: begin
                if (!run)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jericalla_fetch.sv
// Scoreboard bench for jericalla_fetch: stimulus queues expected words,
// a negedge monitor pops and compares every valid output.
module tb_jericalla_fetch;

    localparam logic [17:0] NOP  = 18'h00000;
    localparam logic [17:0] HALT = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [17:0] prog_data = '0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [7:0]  jump_target = '0;
    logic [17:0] instruccion;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q [$];

    jericalla_fetch #(.ADDR_W(8), .NOP_WORD(NOP), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .stall(stall), .jump(jump),
        .jump_target(jump_target), .instruccion(instruccion),
        .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            logic [25:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got instr=%h pc=%h, none expected", instruccion, pc_out);
            end else begin
                e = exp_q.pop_front();
                if ({instruccion, pc_out} !== e) begin
                    errors++;
                    $display("FAIL stream_word got instr=%h pc=%h, expected instr=%h pc=%h",
                             instruccion, pc_out, e[25:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [17:0] w, input logic [7:0] a);
        exp_q.push_back({w, a});
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [17:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic expect_halt_then_idle(input string tag);
        tick();
        chk({tag, "_halted"}, {17'd0, halted}, 18'd1);
        chk({tag, "_valid0"}, {17'd0, instr_valid}, 18'd0);
        chk({tag, "_nop"}, instruccion, NOP);
        tick();
        chk({tag, "_idle"}, {17'd0, halted}, 18'd0);
    endtask

    initial begin
        #3;
        chk("rst_instr", instruccion, NOP);
        chk("rst_valid", {17'd0, instr_valid}, 18'd0);
        chk("rst_pc_out", {10'd0, pc_out}, 18'd0);
        chk("rst_halted", {17'd0, halted}, 18'd0);
        #4 rst_n = 1'b1;
        tick();

        load(8'h00, 18'h08421);
        load(8'h01, 18'h10C63);
        load(8'h02, HALT);
        load(8'h40, 18'h0A5A5);
        load(8'h41, HALT);
        load(8'hFF, 18'h01234);

        // Basic stream ending in HALT
        start();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h10C63, 8'h01); tick();
        expect_halt_then_idle("basic");

        // Three-cycle stall holds the output
        start();
        expect_word(18'h08421, 8'h00); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_word(18'h08421, 8'h00); tick();
        end
        stall = 1'b0;
        expect_word(18'h10C63, 8'h01); tick();
        expect_halt_then_idle("stall");

        // Jump together with stall: bubble then target word
        start();
        expect_word(18'h08421, 8'h00); tick();
        jump = 1'b1; stall = 1'b1; jump_target = 8'h40;
        tick();
        jump = 1'b0; stall = 1'b0;
        chk("jump_bubble", {17'd0, instr_valid}, 18'd0);
        chk("jump_pc_hold", {10'd0, pc_out}, 18'd0);
        expect_word(18'h0A5A5, 8'h40); tick();
        expect_halt_then_idle("jump");

        // PC wrap from 0xFF to 0x00
        start();
        jump = 1'b1; jump_target = 8'hFF;
        tick();
        jump = 1'b0;
        expect_word(18'h01234, 8'hFF); tick();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h10C63, 8'h01); tick();
        expect_halt_then_idle("wrap");

        // HALT holds while run=1 and ignores jump/prog_we
        run = 1'b1;
        tick();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h10C63, 8'h01); tick();
        tick();
        chk("halt_entry", {17'd0, halted}, 18'd1);
        prog_we = 1'b1; prog_addr = 8'h01; prog_data = 18'h2AAAA;
        jump = 1'b1; jump_target = 8'h40;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_hold", {17'd0, halted}, 18'd1);
        end
        prog_we = 1'b0; jump = 1'b0; run = 1'b0;
        tick();
        chk("halt_release", {17'd0, halted}, 18'd0);
        start();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h10C63, 8'h01); tick();
        expect_halt_then_idle("ignored_we");
        load(8'h01, 18'h1F0F0);
        start();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h1F0F0, 8'h01); tick();
        expect_halt_then_idle("idle_we");

        // Asynchronous reset between edges mid-FETCH
        start();
        expect_word(18'h08421, 8'h00); tick();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_instr", instruccion, NOP);
        chk("async_valid", {17'd0, instr_valid}, 18'd0);
        chk("async_pc_out", {10'd0, pc_out}, 18'd0);
        chk("async_halted", {17'd0, halted}, 18'd0);
        tick();
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_instr", instruccion, NOP);
        chk("post_rst_valid", {17'd0, instr_valid}, 18'd0);
        start();
        expect_word(18'h08421, 8'h00); tick();
        expect_word(18'h1F0F0, 8'h01); tick();
        expect_halt_then_idle("refetch");

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_words got %0d left in queue, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
